// File: rtl/hilo_muldiv_if.sv
// EX-stage <-> HI/LO unit bundle: decoded op, forwarded operands, and the
// HI/LO state plus handshake status returned to the pipeline.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [2:0]       op;
  logic             flush;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             rd_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output valid, op, flush, rs_val, rt_val, rd_req,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  valid, op, flush, rs_val, rt_val, rd_req,
    output hi, lo, busy, stall, done
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register unit: mthi/mtlo writes plus an iterative radix-2
// shift-add multiplier (WIDTH steps + sign fix) that stalls dependent ops.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  hilo_muldiv_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d, done_q, done_d;

  logic               is_op, is_signed, busy, stall, acc;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     sum;

  always_comb begin
    is_op     = (bus.op >= 3'd1) && (bus.op <= 3'd4);
    is_signed = (bus.op == 3'd1);
    busy      = (state_q != IDLE);
    stall     = busy & bus.valid & ~bus.flush & (bus.rd_req | is_op);
    acc       = bus.valid & ~bus.flush & ~stall & is_op;
    // The most negative value negates to itself, which is exactly 2^(WIDTH-1) unsigned.
    rs_mag    = (is_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    rt_mag    = (is_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
    sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};

    // NOTE: every _d defaults to its _q first, so no path through the case
    // below leaves a variable unassigned and no latch is inferred.
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (acc) begin
          unique case (bus.op)
            3'd3: hi_d = bus.rs_val;
            3'd4: lo_d = bus.rs_val;
            default: begin
              mcand_d  = rs_mag;
              mplier_d = rt_mag;
              neg_d    = is_signed & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
              prod_d   = '0;
              cnt_d    = '0;
              state_d  = RUN;
            end
          endcase
        end
      end
      RUN: begin
        // Add into the upper half with carry, then shift the whole product right.
        prod_d   = {sum, prod_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        {hi_d, lo_d} = neg_q ? -prod_q : prod_q;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy;
  assign bus.stall = stall;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Lockstep bench for hilo_muldiv_unit: directed scenarios plus random traffic,
// all compared each cycle against a countdown-based behavioural model.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.WIDTH(W)) bus ();
  hilo_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a pending 64-bit result and the number of busy cycles left.
  int          m_left;
  logic [63:0] m_pend;
  logic [31:0] m_hi, m_lo;
  logic        m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_is_op();
    return bus.op inside {3'd1, 3'd2, 3'd3, 3'd4};
  endfunction

  function automatic logic m_stall();
    return (m_left > 0) && bus.valid && !bus.flush && (bus.rd_req || m_is_op());
  endfunction

  task automatic model_reset();
    m_left = 0; m_pend = '0; m_hi = '0; m_lo = '0; m_done = 1'b0;
  endtask

  task automatic model_step();
    longint sa, sb;
    logic   acc;
    if (rst) begin
      model_reset();
      return;
    end
    acc    = bus.valid && !bus.flush && !m_stall() && m_is_op();
    m_done = (m_left == 1);
    if (m_left == 1) {m_hi, m_lo} = m_pend;
    if (m_left > 0) m_left--;
    if (acc) begin
      case (bus.op)
        3'd1: begin
          sa = $signed(bus.rs_val);
          sb = $signed(bus.rt_val);
          m_pend = sa * sb;
          m_left = W + 1;
        end
        3'd2: begin
          m_pend = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
          m_left = W + 1;
        end
        3'd3: m_hi = bus.rs_val;
        default: m_lo = bus.rs_val;
      endcase
    end
  endtask

  // One cycle: apply inputs, compare at the falling edge, advance the model at the rising edge.
  task automatic drive(input logic v, input logic [2:0] op, input logic fl,
                       input logic [31:0] rs, input logic [31:0] rt, input logic rd);
    bus.valid = v; bus.op = op; bus.flush = fl;
    bus.rs_val = rs; bus.rt_val = rt; bus.rd_req = rd;
    @(negedge clk);
    check("stall", bus.stall, m_stall());
    check("busy",  bus.busy,  m_left > 0);
    check("done",  bus.done,  m_done);
    check("hi",    bus.hi,    m_hi);
    check("lo",    bus.lo,    m_lo);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 1'b0, '0, '0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.valid = 1'b0; bus.op = '0; bus.flush = 1'b0;
    bus.rs_val = '0; bus.rt_val = '0; bus.rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);

    // Signed mult 3 * -5: 33 busy cycles, then done cycle with the result.
    drive(1'b1, 3'd1, 1'b0, 32'd3, 32'hFFFF_FFFB, 1'b0);
    idle(W + 1);
    check("m1_done", bus.done, 1'b1);
    check("m1_busy", bus.busy, 1'b0);
    check("m1_hi", bus.hi, 32'hFFFF_FFFF);
    check("m1_lo", bus.lo, 32'hFFFF_FFF1);
    idle(1);
    check("m1_done_pulse", bus.done, 1'b0);

    drive(1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle(W + 1);
    check("mu_hi", bus.hi, 32'hFFFF_FFFE);
    check("mu_lo", bus.lo, 32'h0000_0001);

    drive(1'b1, 3'd1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    idle(W + 1);
    check("mmin_hi", bus.hi, 32'h4000_0000);
    check("mmin_lo", bus.lo, 32'h0000_0000);

    // mfhi waiting on a multiply stalls until the done cycle.
    drive(1'b1, 3'd1, 1'b0, 32'd3, 32'hFFFF_FFFB, 1'b0);
    for (int i = 0; i < W + 1; i++) drive(1'b1, 3'd0, 1'b0, '0, '0, 1'b1);
    check("rd_stall_done", bus.stall, 1'b0);
    check("rd_hi", bus.hi, 32'hFFFF_FFFF);

    // Same with flush: no stall, multiply still completes.
    drive(1'b1, 3'd2, 1'b0, 32'd6, 32'd7, 1'b0);
    for (int i = 0; i < W + 1; i++) drive(1'b1, 3'd0, 1'b1, '0, '0, 1'b1);
    check("fl_done", bus.done, 1'b1);
    check("fl_lo", bus.lo, 32'd42);

    // mthi held behind a multiply, accepted in the done cycle.
    drive(1'b1, 3'd1, 1'b0, 32'd3, 32'hFFFF_FFFB, 1'b0);
    for (int i = 0; i < W + 2; i++) drive(1'b1, 3'd3, 1'b0, 32'h1234_5678, '0, 1'b0);
    check("mthi_hi", bus.hi, 32'h1234_5678);
    check("mthi_lo", bus.lo, 32'hFFFF_FFF1);
    idle(1);

    drive(1'b1, 3'd4, 1'b0, 32'hA5A5_A5A5, '0, 1'b0);
    check("mtlo_lo", bus.lo, 32'hA5A5_A5A5);
    drive(1'b1, 3'd7, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    check("op7_busy", bus.busy, 1'b0);
    check("op7_lo", bus.lo, 32'hA5A5_A5A5);

    // Reset ten cycles into a multiply aborts it.
    drive(1'b1, 3'd2, 1'b0, 32'd7, 32'd9, 1'b0);
    idle(10);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("ab_hi", bus.hi, 32'h0);
    check("ab_lo", bus.lo, 32'h0);
    check("ab_busy", bus.busy, 1'b0);
    check("ab_done", bus.done, 1'b0);
    idle(W + 8);
    check("ab_lo_late", bus.lo, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 7) == 0, pick(), pick(), $urandom_range(0, 3) == 0);
    end
    rst = 1'b0;
    idle(W + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
